adc_sample_sequencer: RTL and testbench



---
 rtl/adc_pkg.sv | 29 ++
 rtl/adc_sample_sequencer_if.sv | 12 +
 rtl/sample_tick_gen.sv | 35 +++
 rtl/adc_sample_sequencer.sv | 145 ++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC sample sequencer and the CPU memory map.
package adc_pkg;

    localparam int unsigned ADC_W  = 12;
    localparam int unsigned RAM_AW = 12;
    localparam int unsigned RAM_DW = 32;
    localparam int unsigned HEAD_W = 10;

    localparam logic [RAM_AW-1:0] EMG_BASE_DEF = 12'h800;
    localparam logic [RAM_AW-1:0] ECG_BASE_DEF = 12'h400;

    typedef enum logic [1:0] {
        IDLE,
        WR_EMG,
        WR_ECG,
        ADV
    } seq_state_e;

    typedef struct packed {
        logic [RAM_AW-1:0] addr;
        logic [RAM_DW-1:0] data;
    } ram_wr_t;

    // Zero-extend an averaged sample into a RAM data word.
    function automatic logic [RAM_DW-1:0] pad_sample(input logic [ADC_W-1:0] s);
        return RAM_DW'(s);
    endfunction

endpackage

// File: rtl/adc_sample_sequencer_if.sv
// Write-only ADC port into data RAM.
interface adc_sample_sequencer_if;
    import adc_pkg::*;

    logic              adc_wEn;
    logic [RAM_AW-1:0] adc_addr;
    logic [RAM_DW-1:0] adc_dataIn;

    modport master (output adc_wEn, adc_addr, adc_dataIn);
    modport slave  (input  adc_wEn, adc_addr, adc_dataIn);

endinterface

// File: rtl/sample_tick_gen.sv
// Enable-gated interval counter; tick_c marks the terminal count.
module sample_tick_gen #(
    parameter int unsigned SAMPLE_INTERVAL = 125000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick_c
);

    localparam int unsigned CNT_W = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_INTERVAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_c = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/adc_sample_sequencer.sv
// Paces EMG/ECG sampling, box-car averages 2^AVG_LOG2 reads and writes
// each averaged pair into per-channel circular buffers in data RAM.
module adc_sample_sequencer
    import adc_pkg::*;
#(
    parameter int unsigned       SAMPLE_INTERVAL = 125000,
    parameter int unsigned       AVG_LOG2        = 2,
    parameter int unsigned       DEPTH           = 640,
    parameter logic [RAM_AW-1:0] EMG_BASE        = EMG_BASE_DEF,
    parameter logic [RAM_AW-1:0] ECG_BASE        = ECG_BASE_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [ADC_W-1:0]       emg_in,
    input  logic [ADC_W-1:0]       ecg_in,
    adc_sample_sequencer_if.master ram,
    output logic [HEAD_W-1:0]      emg_head,
    output logic [HEAD_W-1:0]      ecg_head,
    output logic                   frame_done
);

    localparam int unsigned RD_W  = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
    localparam logic [RD_W-1:0]   RD_LAST   = RD_W'((1 << AVG_LOG2) - 1);
    localparam logic [HEAD_W-1:0] HEAD_LAST = HEAD_W'(DEPTH - 1);

    logic tick_c;

    sample_tick_gen #(.SAMPLE_INTERVAL(SAMPLE_INTERVAL)) u_tick (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .tick_c (tick_c)
    );

    seq_state_e        state_q, state_d;
    logic [RD_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ACC_W-1:0]  acc_emg_q, acc_emg_d, acc_ecg_q, acc_ecg_d;
    logic [ACC_W-1:0]  sum_emg_c, sum_ecg_c;
    logic [ADC_W-1:0]  avg_emg_q, avg_emg_d, avg_ecg_q, avg_ecg_d;
    logic [HEAD_W-1:0] emg_head_q, emg_head_d, ecg_head_q, ecg_head_d;
    logic              wen_q, wen_d;
    logic              frame_done_q, frame_done_d;
    ram_wr_t           wr_q, wr_d;

    always_comb begin
        state_d      = state_q;
        rd_cnt_d     = rd_cnt_q;
        acc_emg_d    = acc_emg_q;
        acc_ecg_d    = acc_ecg_q;
        avg_emg_d    = avg_emg_q;
        avg_ecg_d    = avg_ecg_q;
        emg_head_d   = emg_head_q;
        ecg_head_d   = ecg_head_q;
        wr_d         = wr_q;
        wen_d        = 1'b0;
        frame_done_d = 1'b0;
        sum_emg_c    = acc_emg_q + ACC_W'(emg_in);
        sum_ecg_c    = acc_ecg_q + ACC_W'(ecg_in);

        case (state_q)
            IDLE: begin
                if (tick_c) begin
                    if (rd_cnt_q == RD_LAST) begin
                        avg_emg_d = ADC_W'(sum_emg_c >> AVG_LOG2);
                        avg_ecg_d = ADC_W'(sum_ecg_c >> AVG_LOG2);
                        acc_emg_d = '0;
                        acc_ecg_d = '0;
                        rd_cnt_d  = '0;
                        state_d   = WR_EMG;
                    end else begin
                        acc_emg_d = sum_emg_c;
                        acc_ecg_d = sum_ecg_c;
                        rd_cnt_d  = rd_cnt_q + RD_W'(1);
                    end
                end
            end
            WR_EMG: begin
                wen_d        = 1'b1;
                wr_d.addr    = EMG_BASE + RAM_AW'(emg_head_q);
                wr_d.data    = pad_sample(avg_emg_q);
                state_d      = WR_ECG;
            end
            WR_ECG: begin
                wen_d        = 1'b1;
                wr_d.addr    = ECG_BASE + RAM_AW'(ecg_head_q);
                wr_d.data    = pad_sample(avg_ecg_q);
                state_d      = ADV;
            end
            ADV: begin
                emg_head_d   = (emg_head_q == HEAD_LAST) ? '0 : emg_head_q + HEAD_W'(1);
                ecg_head_d   = (ecg_head_q == HEAD_LAST) ? '0 : ecg_head_q + HEAD_W'(1);
                frame_done_d = (emg_head_q == HEAD_LAST) || (ecg_head_q == HEAD_LAST);
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Dropping enable discards a partial average; a started write sequence still finishes.
        if (!enable) begin
            acc_emg_d = '0;
            acc_ecg_d = '0;
            rd_cnt_d  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rd_cnt_q     <= '0;
            acc_emg_q    <= '0;
            acc_ecg_q    <= '0;
            avg_emg_q    <= '0;
            avg_ecg_q    <= '0;
            emg_head_q   <= '0;
            ecg_head_q   <= '0;
            wen_q        <= 1'b0;
            frame_done_q <= 1'b0;
            wr_q         <= '0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            acc_emg_q    <= acc_emg_d;
            acc_ecg_q    <= acc_ecg_d;
            avg_emg_q    <= avg_emg_d;
            avg_ecg_q    <= avg_ecg_d;
            emg_head_q   <= emg_head_d;
            ecg_head_q   <= ecg_head_d;
            wen_q        <= wen_d;
            frame_done_q <= frame_done_d;
            wr_q         <= wr_d;
        end
    end

    assign ram.adc_wEn    = wen_q;
    assign ram.adc_addr   = wr_q.addr;
    assign ram.adc_dataIn = wr_q.data;
    assign emg_head       = emg_head_q;
    assign ecg_head       = ecg_head_q;
    assign frame_done     = frame_done_q;

    a_heads_locked: assert property (@(posedge clock) disable iff (reset) emg_head_q == ecg_head_q);

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Randomized bench for adc_sample_sequencer: a 4-read averaging instance and a
// no-averaging instance, both checked every cycle against a behavioural model.
module tb_adc_sample_sequencer;

    localparam int SI    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        en0, en1;
    logic [11:0] emg0, ecg0, emg1, ecg1;
    logic [9:0]  emg_head0, ecg_head0, emg_head1, ecg_head1;
    logic        fd0, fd1;

    adc_sample_sequencer_if ram0 ();
    adc_sample_sequencer_if ram1 ();

    adc_sample_sequencer #(.SAMPLE_INTERVAL(SI), .AVG_LOG2(2), .DEPTH(DEPTH)) dut0 (
        .clock(clk), .reset(rst), .enable(en0), .emg_in(emg0), .ecg_in(ecg0),
        .ram(ram0), .emg_head(emg_head0), .ecg_head(ecg_head0), .frame_done(fd0)
    );

    adc_sample_sequencer #(.SAMPLE_INTERVAL(SI), .AVG_LOG2(0), .DEPTH(DEPTH)) dut1 (
        .clock(clk), .reset(rst), .enable(en1), .emg_in(emg1), .ecg_in(ecg1),
        .ram(ram1), .emg_head(emg_head1), .ecg_head(ecg_head1), .frame_done(fd1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit checking = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: enabled-cycle run length decides ticks, a running sum
    // over the group gives the average, then a fixed three-cycle write sequence.
    int m_run [2], m_n [2], m_sume [2], m_sumc [2], m_seq [2], m_head [2];
    int m_avge [2], m_avgc [2], m_addr [2], m_data [2];
    bit m_wen [2], m_fd [2];

    function automatic int navg(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_n[k] = 0; m_sume[k] = 0; m_sumc[k] = 0; m_seq[k] = 0;
            m_head[k] = 0; m_avge[k] = 0; m_avgc[k] = 0; m_addr[k] = 0; m_data[k] = 0;
            m_wen[k] = 1'b0; m_fd[k] = 1'b0;
        end
    endtask

    task automatic m_step(input int k, input bit e, input int ve, input int vc);
        m_wen[k] = 1'b0;
        m_fd[k]  = 1'b0;
        case (m_seq[k])
            1: begin m_wen[k] = 1'b1; m_addr[k] = 'h800 + m_head[k]; m_data[k] = m_avge[k]; m_seq[k] = 2; end
            2: begin m_wen[k] = 1'b1; m_addr[k] = 'h400 + m_head[k]; m_data[k] = m_avgc[k]; m_seq[k] = 3; end
            3: begin m_head[k] = (m_head[k] + 1) % DEPTH; m_fd[k] = (m_head[k] == 0); m_seq[k] = 0; end
            default: ;
        endcase
        if (!e) begin
            m_run[k] = 0; m_n[k] = 0; m_sume[k] = 0; m_sumc[k] = 0;
        end else begin
            m_run[k]++;
            if (m_run[k] % SI == 0) begin
                m_sume[k] += ve;
                m_sumc[k] += vc;
                m_n[k]++;
                if (m_n[k] == navg(k)) begin
                    m_avge[k] = m_sume[k] / navg(k);
                    m_avgc[k] = m_sumc[k] / navg(k);
                    m_n[k] = 0; m_sume[k] = 0; m_sumc[k] = 0;
                    m_seq[k] = 1;
                end
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else begin
                m_step(0, en0, int'(emg0), int'(ecg0));
                m_step(1, en1, int'(emg1), int'(ecg1));
            end
        end
    end

    task automatic cmp(input int k, input logic wen, input logic [11:0] addr, input logic [31:0] data,
                       input logic [9:0] eh, input logic [9:0] ch, input logic fd);
        total++;
        if (wen !== m_wen[k] || addr !== 12'(m_addr[k]) || data !== 32'(m_data[k]) ||
            eh !== 10'(m_head[k]) || ch !== 10'(m_head[k]) || fd !== m_fd[k]) begin
            bad++;
            $display("FAIL model_cmp dut%0d cyc=%0d got wen=%b addr=%h data=%h heads=%0d/%0d fd=%b want wen=%b addr=%h data=%h head=%0d fd=%b",
                     k, cyc, wen, addr, data, eh, ch, fd, m_wen[k], 12'(m_addr[k]), 32'(m_data[k]), m_head[k], m_fd[k]);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (checking && !rst) begin
            cmp(0, ram0.adc_wEn, ram0.adc_addr, ram0.adc_dataIn, emg_head0, ecg_head0, fd0);
            cmp(1, ram1.adc_wEn, ram1.adc_addr, ram1.adc_dataIn, emg_head1, ecg_head1, fd1);
        end
    end

    always @(negedge clk) ecg1 <= 12'($urandom_range(4095, 0));

    // Observed frame pulses and EMG write addresses on instance 0.
    bit mon_on = 1'b0;
    int fd_cnt = 0;
    int emg_addrs [$];
    initial forever begin
        @(negedge clk);
        if (mon_on && !rst) begin
            if (fd0 === 1'b1) fd_cnt++;
            if (ram0.adc_wEn === 1'b1 && ram0.adc_addr >= 12'h800) emg_addrs.push_back(int'(ram0.adc_addr));
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick_wait0();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(en0 && m_run[0] > 0 && m_run[0] % SI == 0) && n < 3 * SI);
        if (n >= 3 * SI) begin
            total++; bad++;
            $display("FAIL tick_timeout got=none want=tick within %0d cycles", 3 * SI);
        end
    endtask

    task automatic wait_wen(input int k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((k == 0) ? ram0.adc_wEn : ram1.adc_wEn) !== 1'b1 && n < 200);
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL wen_timeout dut%0d got=no strobe want=strobe within 200 cycles", k);
        end
    endtask

    task automatic feed0(input int a, input int b, input int c, input int d);
        emg0 = 12'(a); tick_wait0();
        emg0 = 12'(b); tick_wait0();
        emg0 = 12'(c); tick_wait0();
        emg0 = 12'(d); tick_wait0();
    endtask

    initial begin
        int t0;
        int wcount;
        en0 = 1'b0; en1 = 1'b0;
        emg0 = '0; ecg0 = '0; emg1 = 12'hFFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        chk("reset_wen",  64'(ram0.adc_wEn), 64'(0));
        chk("reset_addr", 64'(ram0.adc_addr), 64'(0));
        chk("reset_data", 64'(ram0.adc_dataIn), 64'(0));
        chk("reset_head", 64'(emg_head0), 64'(0));

        // Constant inputs: first write latency and both words.
        emg0 = 12'h100; ecg0 = 12'h0F0; en0 = 1'b1; en1 = 1'b1;
        t0 = cyc;
        wait_wen(0);
        chk("t1_latency",  64'(cyc - t0), 64'(33));
        chk("t1_emg_addr", 64'(ram0.adc_addr), 64'(12'h800));
        chk("t1_emg_data", 64'(ram0.adc_dataIn), 64'(32'h100));
        @(negedge clk);
        chk("t1_ecg_wen",  64'(ram0.adc_wEn), 64'(1));
        chk("t1_ecg_addr", 64'(ram0.adc_addr), 64'(12'h400));
        chk("t1_ecg_data", 64'(ram0.adc_dataIn), 64'(32'h0F0));
        @(negedge clk);
        chk("t1_heads", 64'({emg_head0, ecg_head0}), 64'({10'd1, 10'd1}));

        // Ramp average and truncation.
        feed0(4, 8, 12, 16);
        wait_wen(0);
        chk("t2_ramp_avg", 64'(ram0.adc_dataIn), 64'(10));
        chk("t2_model_ramp", 64'(m_data[0]), 64'(10));
        feed0(1, 1, 1, 2);
        wait_wen(0);
        chk("t2_trunc_avg", 64'(ram0.adc_dataIn), 64'(1));

        // Sixteen random averaging periods: wrap addresses and frame pulses.
        fd_cnt = 0;
        emg_addrs.delete();
        mon_on = 1'b1;
        for (int i = 0; i < 64; i++) begin
            emg0 = 12'($urandom_range(4095, 0));
            ecg0 = 12'($urandom_range(4095, 0));
            tick_wait0();
        end
        repeat (4) @(negedge clk);
        mon_on = 1'b0;
        chk("t3_fd_count", 64'(fd_cnt), 64'(4));
        chk("t3_writes", 64'(emg_addrs.size()), 64'(16));
        for (int i = 0; i < emg_addrs.size() && i < 16; i++)
            chk($sformatf("t3_addr%0d", i), 64'(emg_addrs[i]), 64'(32'h800 + (3 + i) % 4));

        // Enable dropped mid-average: partial sum discarded, counter restarts.
        emg0 = 12'h100;
        tick_wait0();
        tick_wait0();
        en0 = 1'b0;
        repeat (5) @(negedge clk);
        emg0 = 12'h040; en0 = 1'b1;
        t0 = cyc;
        feed0('h40, 'h40, 'h40, 'h80);
        wait_wen(0);
        chk("t5_latency", 64'(cyc - t0), 64'(33));
        chk("t5_avg", 64'(ram0.adc_dataIn), 64'(32'h50));

        // Reset while an EMG write is on the bus.
        emg0 = 12'($urandom_range(4095, 0));
        wait_wen(0);
        #2 rst = 1'b1;
        #1;
        chk("t4_wen_async",  64'(ram0.adc_wEn), 64'(0));
        chk("t4_addr_async", 64'(ram0.adc_addr), 64'(0));
        chk("t4_data_async", 64'(ram0.adc_dataIn), 64'(0));
        chk("t4_head_async", 64'(emg_head0), 64'(0));
        en0 = 1'b0;
        wcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            if (ram0.adc_wEn !== 1'b0) wcount++;
        end
        chk("t4_no_ecg_write", 64'(wcount), 64'(0));

        // No averaging: every tick writes the raw full-scale EMG value.
        wait_wen(1);
        chk("t6_emg_data", 64'(ram1.adc_dataIn), 64'(32'h00000FFF));
        @(negedge clk);
        chk("t6_wen_ecg", 64'(ram1.adc_wEn), 64'(1));
        @(negedge clk);
        chk("t6_wen_gap", 64'(ram1.adc_wEn), 64'(0));
        wait_wen(1);
        chk("t6_emg_data2", 64'(ram1.adc_dataIn), 64'(32'h00000FFF));

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
